// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge.
// Qualifies transfers, issues one request to the APB stage, stalls until done.
module ahb_slave_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        Pclk,
  input  logic        Presetn,
  input  logic        Hsel,
  input  logic [31:0] Haddr,
  input  logic        Hwrite,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Hwdata,
  input  logic        Hready_in,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  output logic [32:0] addr_temp,
  output logic [31:0] data_temp,
  output logic        transfer,
  input  logic [31:0] rdata_temp,
  input  logic        xfer_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_BUSY, S_DONE, S_ERR1, S_ERR2
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic [32:0]   r_addr;
  logic [31:0]   r_data;
  logic [31:0]   r_rdata;
  logic          r_xfer;

  logic w_valid;
  logic w_legal;
  logic w_sample;
  logic w_tmo;
  logic w_unused;

  assign w_unused = Htrans[0];
  assign w_valid  = Hsel & Hready_in & Htrans[1];
  assign w_legal  = (Hsize == 3'b010) && (Haddr[1:0] == 2'b00);
  assign w_sample = (r_state == S_IDLE) || (r_state == S_DONE)
                 || (r_state == S_ERR2);
  assign w_tmo    = (TIMEOUT != 0) && (r_cnt == TMO_LAST);

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (w_valid) w_next = w_legal ? S_DATA : S_ERR1;
        else         w_next = S_IDLE;
      end
      S_DATA: w_next = S_BUSY;
      S_BUSY: begin
        if (xfer_done)  w_next = S_DONE;
        else if (w_tmo) w_next = S_ERR1;
      end
      S_ERR1: w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    unique case (r_state)
      S_DATA, S_BUSY: Hreadyout = 1'b0;
      S_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = 2'b01;
      end
      S_ERR2: Hresp = 2'b01;
      default: ;
    endcase
  end

  // Request datapath; the write flag rides in r_addr[32].
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_xfer  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_sample && w_valid && w_legal)
        r_addr <= {Hwrite, Haddr};
      if (r_state == S_DATA) begin
        r_data <= r_addr[32] ? Hwdata : 32'h0;
        r_xfer <= 1'b1;
        r_cnt  <= '0;
      end else if (r_state == S_BUSY) begin
        if (xfer_done) begin
          r_xfer <= 1'b0;
          if (!r_addr[32]) r_rdata <= rdata_temp;
        end else if (w_tmo) begin
          r_xfer <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign addr_temp = r_addr;
  assign data_temp = r_data;
  assign Hrdata    = r_rdata;
  assign transfer  = r_xfer;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if.
// Runs with TIMEOUT=4; Hready_in follows the slave's own Hreadyout.
module tb_ahb_slave_if;

  logic        Pclk = 1'b0;
  logic        Presetn;
  logic        Hsel;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [31:0] Hwdata;
  wire         Hready_in;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [32:0] addr_temp;
  logic [31:0] data_temp;
  logic        transfer;
  logic [31:0] rdata_temp;
  logic        xfer_done;

  int n_checks = 0;
  int n_fail   = 0;

  assign Hready_in = Hreadyout;

  always #5 Pclk = ~Pclk;

  ahb_slave_if #(.TIMEOUT(4)) dut (
    .Pclk       (Pclk),
    .Presetn    (Presetn),
    .Hsel       (Hsel),
    .Haddr      (Haddr),
    .Hwrite     (Hwrite),
    .Htrans     (Htrans),
    .Hsize      (Hsize),
    .Hwdata     (Hwdata),
    .Hready_in  (Hready_in),
    .Hreadyout  (Hreadyout),
    .Hresp      (Hresp),
    .Hrdata     (Hrdata),
    .addr_temp  (addr_temp),
    .data_temp  (data_temp),
    .transfer   (transfer),
    .rdata_temp (rdata_temp),
    .xfer_done  (xfer_done)
  );

  task automatic chk(input string tag, input logic [32:0] obs,
                     input logic [32:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic idle_bus();
    Hsel   = 1'b0;
    Htrans = 2'b00;
    Hsize  = 3'b010;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w,
                            input logic [2:0] sz);
    Hsel   = 1'b1;
    Haddr  = a;
    Hwrite = w;
    Htrans = 2'b10;
    Hsize  = sz;
  endtask

  initial begin
    Presetn    = 1'b0;
    Hsel       = 1'($urandom);
    Haddr      = $urandom;
    Hwrite     = 1'($urandom);
    Htrans     = 2'($urandom);
    Hsize      = 3'($urandom);
    Hwdata     = $urandom;
    rdata_temp = $urandom;
    xfer_done  = 1'($urandom);
    tick();
    tick();
    chk("rst_hready", 33'(Hreadyout), 33'h1);
    chk("rst_hresp",  33'(Hresp),     33'h0);
    chk("rst_hrdata", 33'(Hrdata),    33'h0);
    chk("rst_addr",   addr_temp,      33'h0);
    chk("rst_data",   33'(data_temp), 33'h0);
    chk("rst_xfer",   33'(transfer),  33'h0);
    idle_bus();
    xfer_done = 1'b0;
    tick();
    Presetn = 1'b1;
    tick();

    // single write
    addr_phase(32'h10, 1'b1, 3'b010);
    tick();
    chk("wr_addr",    addr_temp,      33'h1_0000_0010);
    chk("wr_dat_rdy", 33'(Hreadyout), 33'h0);
    chk("wr_dat_xfr", 33'(transfer),  33'h0);
    idle_bus();
    Hwdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_data",    33'(data_temp), 33'hDEAD_BEEF);
    chk("wr_b1_xfr",  33'(transfer),  33'h1);
    chk("wr_b1_rdy",  33'(Hreadyout), 33'h0);
    Hwdata = 32'h0;
    tick();
    chk("wr_b2_xfr",  33'(transfer),  33'h1);
    chk("wr_b2_rdy",  33'(Hreadyout), 33'h0);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("wr_done_rdy",  33'(Hreadyout), 33'h1);
    chk("wr_done_resp", 33'(Hresp),     33'h0);
    chk("wr_done_xfr",  33'(transfer),  33'h0);
    chk("wr_hrdata",    33'(Hrdata),    33'h0);
    tick();

    // single read
    addr_phase(32'h20, 1'b0, 3'b010);
    tick();
    chk("rd_addr", addr_temp, 33'h0_0000_0020);
    idle_bus();
    Hwdata = 32'hAAAA_AAAA;
    tick();
    chk("rd_data0", 33'(data_temp), 33'h0);
    chk("rd_xfer",  33'(transfer),  33'h1);
    xfer_done  = 1'b1;
    rdata_temp = 32'h1234_5678;
    tick();
    xfer_done  = 1'b0;
    rdata_temp = 32'hFFFF_FFFF;
    chk("rd_hrdata", 33'(Hrdata),    33'h1234_5678);
    chk("rd_rdy",    33'(Hreadyout), 33'h1);
    chk("rd_xfr0",   33'(transfer),  33'h0);
    tick();

    // pipelined write then read, second address held in wait states
    addr_phase(32'h40, 1'b1, 3'b010);
    tick();
    addr_phase(32'h44, 1'b0, 3'b010);
    Hwdata = 32'hCAFE_F00D;
    tick();
    chk("pw_data", 33'(data_temp), 33'hCAFE_F00D);
    chk("pw_addr", addr_temp,      33'h1_0000_0040);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("pw_done_rdy",  33'(Hreadyout), 33'h1);
    chk("pw_done_addr", addr_temp,      33'h1_0000_0040);
    tick();
    chk("pr_addr", addr_temp,      33'h0_0000_0044);
    chk("pr_rdy",  33'(Hreadyout), 33'h0);
    idle_bus();
    tick();
    chk("pr_xfer", 33'(transfer),  33'h1);
    chk("pr_data", 33'(data_temp), 33'h0);
    xfer_done  = 1'b1;
    rdata_temp = 32'h0BAD_F00D;
    tick();
    xfer_done = 1'b0;
    chk("pr_hrdata", 33'(Hrdata), 33'h0BAD_F00D);
    tick();

    // illegal halfword
    addr_phase(32'h50, 1'b1, 3'b001);
    tick();
    idle_bus();
    chk("hw_e1_resp", 33'(Hresp),     33'h1);
    chk("hw_e1_rdy",  33'(Hreadyout), 33'h0);
    chk("hw_e1_xfr",  33'(transfer),  33'h0);
    tick();
    chk("hw_e2_resp", 33'(Hresp),     33'h1);
    chk("hw_e2_rdy",  33'(Hreadyout), 33'h1);
    chk("hw_e2_xfr",  33'(transfer),  33'h0);
    chk("hw_addr",    addr_temp,      33'h0_0000_0044);
    tick();
    chk("hw_idle_resp", 33'(Hresp), 33'h0);

    // illegal misaligned
    addr_phase(32'h2, 1'b0, 3'b010);
    tick();
    idle_bus();
    chk("ma_e1_resp", 33'(Hresp),     33'h1);
    chk("ma_e1_rdy",  33'(Hreadyout), 33'h0);
    tick();
    chk("ma_e2_resp", 33'(Hresp),     33'h1);
    chk("ma_e2_rdy",  33'(Hreadyout), 33'h1);
    chk("ma_e2_xfr",  33'(transfer),  33'h0);
    tick();

    // timeout after 4 BUSY cycles
    addr_phase(32'h60, 1'b1, 3'b010);
    tick();
    idle_bus();
    Hwdata = 32'h1111_2222;
    tick();
    chk("to_b1_xfr", 33'(transfer), 33'h1);
    tick();
    tick();
    tick();
    chk("to_b4_xfr", 33'(transfer),  33'h1);
    chk("to_b4_rdy", 33'(Hreadyout), 33'h0);
    tick();
    chk("to_e1_xfr",  33'(transfer),  33'h0);
    chk("to_e1_resp", 33'(Hresp),     33'h1);
    chk("to_e1_rdy",  33'(Hreadyout), 33'h0);
    tick();
    chk("to_e2_resp", 33'(Hresp),     33'h1);
    chk("to_e2_rdy",  33'(Hreadyout), 33'h1);
    tick();

    // reset mid-BUSY
    addr_phase(32'h70, 1'b0, 3'b010);
    tick();
    idle_bus();
    tick();
    chk("mr_busy_xfr", 33'(transfer), 33'h1);
    Presetn = 1'b0;
    #1;
    chk("mr_xfr",  33'(transfer),  33'h0);
    chk("mr_rdy",  33'(Hreadyout), 33'h1);
    chk("mr_resp", 33'(Hresp),     33'h0);
    chk("mr_addr", addr_temp,      33'h0);
    tick();
    Presetn = 1'b1;
    tick();
    xfer_done  = 1'b1;
    rdata_temp = 32'h0000_0055;
    tick();
    xfer_done = 1'b0;
    chk("mr_ign_rdata", 33'(Hrdata),    33'h0);
    chk("mr_ign_rdy",   33'(Hreadyout), 33'h1);
    chk("mr_ign_xfr",   33'(transfer),  33'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
